prog_load_checker: RTL and testbench
====================================

Name: prog_load_checker

Overview:
- Synthesizable program-load and result-check harness for the pipelined 8-bit CPU wrapper.
- Holds the CPU in reset while a byte stream of (address, data) pairs is written into unified memory.
- Then holds reset for a programmable number of cycles, releases the CPU, and runs it for a bounded cycle budget.
- While running, compares a probed CPU value (e.g. a register-file entry) against an expected value and reports pass, fail, or timeout.
- Replaces ad-hoc hierarchical memory pokes and fixed delays with a parametrised, reusable sequencer for FPGA and simulation bring-up.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data and probe width.
- CNT_W, 16, width of the run-cycle counter and budget.
- RST_HOLD, 2, cycles the CPU stays in reset after the last load write (minimum 1).
- EARLY_EXIT, 1, 1: finish as soon as the probe matches; 0: check only at budget expiry.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ld_valid  in  1  load beat valid
- ld_ready  out  1  load beat accepted when ld_valid && ld_ready
- ld_addr  in  ADDR_W  load target address
- ld_data  in  DATA_W  load data
- ld_last  in  1  marks the final beat of the program image
- run_cycles  in  CNT_W  run budget; sampled when the last beat is accepted
- chk_value  in  DATA_W  expected probe value; sampled when the last beat is accepted
- obs_value  in  DATA_W  probed CPU value
- restart  in  1  single-cycle pulse; re-enters LOAD from DONE
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory write address
- mem_wdata  out  DATA_W  memory write data
- cpu_rstn  out  1  active-low reset to the CPU
- done  out  1  run finished (sticky)
- pass  out  1  probe matched (sticky, valid while done)
- fail  out  1  budget expired without a match (sticky, valid while done)
- cycles_used  out  CNT_W  number of RUN cycles elapsed
- beats  out  ADDR_W+1  count of accepted load beats, saturating

Behaviour:
- Reset values: state LOAD, ld_ready 1, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rstn 0. done, pass and fail are 0. cycles_used and beats are 0.
- States: LOAD, HOLD, RUN, DONE.
- LOAD:
  - ld_ready=1 and cpu_rstn=0.
  - Each accepted beat registers addr/data and pulses mem_we for exactly 1 cycle on the next cycle (1-cycle latency).
  - Back-to-back beats sustain 1 write per cycle.
  - beats increments per accepted beat and saturates at all-ones.
  - An accepted beat with ld_last=1 samples run_cycles and chk_value, then moves to HOLD on the same edge. That final write still issues in the first HOLD cycle.
- HOLD:
  - ld_ready=0 and cpu_rstn=0.
  - Lasts RST_HOLD cycles, then goes to RUN.
- RUN:
  - cpu_rstn=1.
  - cycles_used increments every RUN cycle.
  - Match means obs_value == sampled chk_value.
  - With EARLY_EXIT=1, a match in any RUN cycle sets done and pass and moves to DONE.
  - When cycles_used reaches the sampled budget, the probe is compared. A match sets pass; otherwise fail is set. Either way done is set and the state moves to DONE.
  - A budget of 0 is checked in the first RUN cycle.
  - If a match and budget expiry occur in the same cycle, pass wins.
- DONE:
  - cpu_rstn stays 1 (the CPU free-runs for waveform inspection).
  - Outputs are frozen; ld_ready=0.
  - restart=1 clears done, pass, fail, cycles_used and beats, drives cpu_rstn=0, and returns to LOAD.
  - restart is ignored in all other states.
- Ignored inputs: ld_valid is ignored outside LOAD, and ld_ready=0 there.
- pass and fail are mutually exclusive; both are 0 while done is 0.
- Reset mid-operation (any state): immediate return to the reset values. Any pending mem_we is dropped and cpu_rstn=0 asynchronously.
- Widths: cycles_used never wraps; it stops at the budget. Comparison is a full DATA_W equality.

Decomposition:
- Shared package `plc_pkg`: state enum (LOAD, HOLD, RUN, DONE) and a localparam for the beat-count saturation value.
- One sub-module, `plc_write_stage`: the registered addr/data/we stage between the load handshake and the memory port.
- The FSM and counters stay in the top module.

Test Plan:
- Load 0x00, 0x00, 0xC5, 0xF0 to addresses 0–3 and 0xAA to address 0xF0 (ld_last on the 0xF0 beat), with chk_value=0xAA, run_cycles=10, EARLY_EXIT=1.
  - Expect 5 mem_we pulses, each one cycle after its beat, and beats=5.
  - Expect cpu_rstn low for RST_HOLD cycles after the last beat.
  - Expect done=1 and pass=1 with cycles_used ≤ 10.
- Same program, chk_value=0x55, run_cycles=10 → done=1 and fail=1 exactly when cycles_used=10; pass=0.
- run_cycles=0, obs_value tied to 0x3C, chk_value=0x3C → pass in the first RUN cycle; cycles_used ≤ 1.
- EARLY_EXIT=0, probe matches from cycle 2, run_cycles=8 → done is not asserted before cycles_used=8; then pass=1.
- Assert rst for 1 cycle during RUN at cycle 4 → cpu_rstn=0 immediately; state LOAD; done, pass, fail, cycles_used and beats all 0. A reload then completes a normal pass.
- From DONE, pulse restart and reload with 3 beats → flags clear, beats=3, and mem_we issues 3 pulses. A restart pulse applied during LOAD has no effect.

Source files
------------

// File: rtl/plc_pkg.sv
// plc_pkg: shared state encoding and constants for the program-load checker
package plc_pkg;
  typedef enum logic [1:0] {LOAD, HOLD, RUN, DONE} state_t;
  localparam logic [31:0] BEATS_SAT_ALL = '1;
endpackage

// File: rtl/plc_write_stage.sv
// plc_write_stage: registers an accepted load beat into a one-cycle memory write
module plc_write_stage #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we        <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      we <= accept;
      if (accept) begin
        mem_addr  <= addr;
        mem_wdata <= data;
      end
    end
endmodule

// File: rtl/prog_load_checker.sv
// prog_load_checker: loads a program image, holds/releases CPU reset, runs and checks a probe
module prog_load_checker
  import plc_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 16,
  parameter int RST_HOLD   = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic [DATA_W-1:0] chk_value,
  input  logic [DATA_W-1:0] obs_value,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [CNT_W-1:0]  cycles_used,
  output logic [ADDR_W:0]   beats
);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [ADDR_W:0] SAT = BEATS_SAT_ALL[ADDR_W:0];
  state_t state, state_nx;
  logic [CNT_W-1:0] budget;
  logic [DATA_W-1:0] chk;
  logic [HW-1:0] hcnt;
  logic accept, match, expire, finish, hold_end;
  plc_write_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_write (
    .clk(clk), .rst(rst), .accept(accept), .addr(ld_addr), .data(ld_data),
    .we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );
  always_comb begin
    ld_ready = state == LOAD;
    cpu_rstn = state == RUN || state == DONE;
    accept   = ld_valid && ld_ready;
    match    = obs_value == chk;
    expire   = cycles_used == budget;
    finish   = ((EARLY_EXIT != 0) && match) || expire;
    hold_end = hcnt == HW'(RST_HOLD - 1);
    state_nx = (state == LOAD && accept && ld_last) ? HOLD :
               (state == HOLD && hold_end)          ? RUN  :
               (state == RUN && finish)             ? DONE :
               (state == DONE && restart)           ? LOAD : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= LOAD;
      hcnt        <= '0;
      budget      <= '0;
      chk         <= '0;
      cycles_used <= '0;
      beats       <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state <= state_nx;
      hcnt  <= (state == HOLD) ? hcnt + 1'b1 : '0;
      if (accept) begin
        if (beats != SAT) beats <= beats + 1'b1;
        if (ld_last) begin
          budget <= run_cycles;
          chk    <= chk_value;
        end
      end
      // the finishing cycle is not counted, so cycles_used stops at the budget
      if (state == RUN) begin
        if (finish) begin
          done <= 1'b1;
          pass <= match;
          fail <= !match;
        end else cycles_used <= cycles_used + 1'b1;
      end
      if (state == DONE && restart) begin
        done        <= 1'b0;
        pass        <= 1'b0;
        fail        <= 1'b0;
        cycles_used <= '0;
        beats       <= '0;
      end
    end
endmodule

// File: tb/tb_prog_load_checker.sv
// tb_prog_load_checker: directed checks of load, hold, run, restart and reset behaviour
module tb_prog_load_checker;
  logic clk = 1'b0;
  logic rst, ld_valid, ld_last, restart;
  logic [7:0] ld_addr, ld_data, chk_value, obs_value;
  logic [15:0] run_cycles;
  logic ld_ready, mem_we, cpu_rstn, done, pass, fail;
  logic [7:0] mem_addr, mem_wdata;
  logic [15:0] cycles_used;
  logic [8:0] beats;
  logic n_ld_ready, n_mem_we, n_cpu_rstn, n_done, n_pass, n_fail;
  logic [7:0] n_mem_addr, n_mem_wdata;
  logic [15:0] n_cycles_used;
  logic [8:0] n_beats;
  int checks = 0, passed = 0, we_cnt = 0;

  prog_load_checker #(.EARLY_EXIT(1)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .run_cycles(run_cycles), .chk_value(chk_value),
    .obs_value(obs_value), .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rstn(cpu_rstn), .done(done), .pass(pass), .fail(fail),
    .cycles_used(cycles_used), .beats(beats)
  );
  prog_load_checker #(.EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(n_ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .run_cycles(run_cycles), .chk_value(chk_value),
    .obs_value(obs_value), .restart(restart), .mem_we(n_mem_we), .mem_addr(n_mem_addr),
    .mem_wdata(n_mem_wdata), .cpu_rstn(n_cpu_rstn), .done(n_done), .pass(n_pass), .fail(n_fail),
    .cycles_used(n_cycles_used), .beats(n_beats)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (mem_we) we_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] d, input logic last);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== d)
      $display("FAIL write we=%b addr=%h data=%h want we=1 addr=%h data=%h", mem_we, mem_addr, mem_wdata, a, d);
    else passed++;
  endtask

  task automatic load_prog(input logic [7:0] chk, input logic [15:0] budget);
    chk_value = chk; run_cycles = budget;
    beat(8'h00, 8'h00, 1'b0);
    beat(8'h01, 8'h00, 1'b0);
    beat(8'h02, 8'hC5, 1'b0);
    beat(8'h03, 8'hF0, 1'b0);
    beat(8'hF0, 8'hAA, 1'b1);
    checks++;
    if (ld_ready !== 1'b0 || cpu_rstn !== 1'b0)
      $display("FAIL hold1 ld_ready=%b cpu_rstn=%b want 0 0", ld_ready, cpu_rstn);
    else passed++;
    step();
    checks++;
    if (mem_we !== 1'b0 || cpu_rstn !== 1'b0)
      $display("FAIL hold2 mem_we=%b cpu_rstn=%b want 0 0", mem_we, cpu_rstn);
    else passed++;
    step();
    checks++;
    if (cpu_rstn !== 1'b1) $display("FAIL release cpu_rstn=%b want 1", cpu_rstn);
    else passed++;
  endtask

  task automatic sync_done();
    int n = 0;
    while (!(done && n_done) && n < 60) begin step(); n++; end
    checks++;
    if (!(done && n_done)) $display("FAIL done_timeout done=%b n_done=%b want 1 1", done, n_done);
    else passed++;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if ({done, pass, fail, cpu_rstn, ld_ready} !== 5'b00001 || cycles_used !== 16'd0 || beats !== 9'd0)
      $display("FAIL restart flags=%b cycles=%0d beats=%0d want 00001 0 0",
               {done, pass, fail, cpu_rstn, ld_ready}, cycles_used, beats);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; restart = 1'b0;
    ld_addr = '0; ld_data = '0; chk_value = '0; obs_value = '0; run_cycles = '0;
    step(); step();
    checks++;
    if ({ld_ready, mem_we, cpu_rstn, done, pass, fail} !== 6'b100000 || mem_addr !== 8'd0 ||
        mem_wdata !== 8'd0 || cycles_used !== 16'd0 || beats !== 9'd0)
      $display("FAIL reset flags=%b addr=%h data=%h cycles=%0d beats=%0d want 100000 0 0 0 0",
               {ld_ready, mem_we, cpu_rstn, done, pass, fail}, mem_addr, mem_wdata, cycles_used, beats);
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_pass();
    int w0 = we_cnt;
    obs_value = 8'hAA;
    load_prog(8'hAA, 16'd10);
    checks++;
    if (we_cnt - w0 !== 5 || beats !== 9'd5)
      $display("FAIL load_count pulses=%0d beats=%0d want 5 5", we_cnt - w0, beats);
    else passed++;
    step();
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || fail !== 1'b0 || cycles_used > 16'd10)
      $display("FAIL early_pass done=%b pass=%b fail=%b cycles=%0d want 1 1 0 <=10", done, pass, fail, cycles_used);
    else passed++;
    sync_done();
  endtask

  task automatic test_fail();
    bit early = 1'b0;
    pulse_restart();
    obs_value = 8'h00;
    load_prog(8'h55, 16'd10);
    for (int i = 0; i < 10; i++) begin step(); if (done) early = 1'b1; end
    checks++;
    if (early || cycles_used !== 16'd10) $display("FAIL fail_early done_seen=%b cycles=%0d want 0 10", early, cycles_used);
    else passed++;
    step();
    checks++;
    if (done !== 1'b1 || fail !== 1'b1 || pass !== 1'b0 || cycles_used !== 16'd10)
      $display("FAIL expiry done=%b fail=%b pass=%b cycles=%0d want 1 1 0 10", done, fail, pass, cycles_used);
    else passed++;
    sync_done();
  endtask

  task automatic test_zero_budget();
    pulse_restart();
    obs_value = 8'h3C;
    load_prog(8'h3C, 16'd0);
    step();
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || fail !== 1'b0 || cycles_used > 16'd1)
      $display("FAIL zero_budget done=%b pass=%b fail=%b cycles=%0d want 1 1 0 <=1", done, pass, fail, cycles_used);
    else passed++;
    sync_done();
  endtask

  task automatic test_no_early();
    bit early = 1'b0;
    pulse_restart();
    obs_value = 8'h00;
    load_prog(8'h77, 16'd8);
    step(); step();
    obs_value = 8'h77;
    for (int i = 0; i < 6; i++) begin step(); if (n_done) early = 1'b1; end
    checks++;
    if (early || n_cycles_used !== 16'd8) $display("FAIL no_early done_seen=%b cycles=%0d want 0 8", early, n_cycles_used);
    else passed++;
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || cycles_used !== 16'd2)
      $display("FAIL early_ref done=%b pass=%b cycles=%0d want 1 1 2", done, pass, cycles_used);
    else passed++;
    step();
    checks++;
    if (n_done !== 1'b1 || n_pass !== 1'b1 || n_fail !== 1'b0 || n_cycles_used !== 16'd8)
      $display("FAIL late_pass done=%b pass=%b fail=%b cycles=%0d want 1 1 0 8", n_done, n_pass, n_fail, n_cycles_used);
    else passed++;
    sync_done();
  endtask

  task automatic test_reset_mid_run();
    pulse_restart();
    obs_value = 8'h00;
    load_prog(8'h99, 16'd10);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    #1;
    checks++;
    if ({cpu_rstn, ld_ready, mem_we, done, pass, fail} !== 6'b010000 || cycles_used !== 16'd0 || beats !== 9'd0)
      $display("FAIL mid_reset flags=%b cycles=%0d beats=%0d want 010000 0 0",
               {cpu_rstn, ld_ready, mem_we, done, pass, fail}, cycles_used, beats);
    else passed++;
    step();
    rst = 1'b0;
    obs_value = 8'h99;
    load_prog(8'h99, 16'd10);
    step();
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || fail !== 1'b0)
      $display("FAIL reload_pass done=%b pass=%b fail=%b want 1 1 0", done, pass, fail);
    else passed++;
    sync_done();
  endtask

  task automatic test_restart();
    int w0;
    pulse_restart();
    w0 = we_cnt;
    beat(8'h10, 8'h11, 1'b0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (beats !== 9'd1 || ld_ready !== 1'b1 || cpu_rstn !== 1'b0)
      $display("FAIL restart_in_load beats=%0d ld_ready=%b cpu_rstn=%b want 1 1 0", beats, ld_ready, cpu_rstn);
    else passed++;
    beat(8'h11, 8'h22, 1'b0);
    beat(8'h12, 8'h33, 1'b1);
    step();
    checks++;
    if (beats !== 9'd3 || we_cnt - w0 !== 3)
      $display("FAIL reload3 beats=%0d pulses=%0d want 3 3", beats, we_cnt - w0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_zero_budget();
    test_no_early();
    test_reset_mid_run();
    test_restart();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
